// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared types and constants for the core front end
// Rev 1.0
// ============================================================================
`default_nettype none

package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// fetch_buffer : in-order circular FIFO of {pc, instr} entries with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t push_entry,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : fetch PC owner, feeds zero-latency imem into a decode buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign_err
);

   logic [XLEN-1:0] fetch_pc;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   fetch_entry_t    head;
   fetch_entry_t    fetch_entry;

   assign imem_pc     = fetch_pc;
   assign out_valid   = !empty;
   assign pop         = out_valid & out_ready;
   // A full buffer can still accept when the head leaves in the same cycle.
   assign push        = !redirect_valid & (!full | pop);
   assign fetch_entry = '{pc: fetch_pc, instr: imem_instr};

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (push),
      .pop        (pop),
      .push_entry (fetch_entry),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc     <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         if (redirect_valid)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         else if (push)
            fetch_pc <= fetch_pc + 32'd4;
         if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            misalign_err <= 1'b1;
      end
   end

   assign out_instr = out_valid ? head.instr : NOP_INSTR;
   assign out_pc    = out_valid ? head.pc    : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed + random stimulus, queue model and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
   import core_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign_err;

   logic [31:0] mem [1024];

   int checks    = 0;
   int errors    = 0;
   int delivered = 0;

   // Reference model: fetched entries awaiting decode, plus fetch address.
   fetch_entry_t mq[$];
   fetch_entry_t exp_q[$];
   logic [31:0]  mpc = RESET_PC;
   bit           mmis = 1'b0;
   bit           started = 1'b0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_pc[11:2]];

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .misalign_err   (misalign_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after each rising edge, so both model and DUT
   // see stable values at the edge.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
      rst_n          = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      out_ready      = rdy;
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      fetch_entry_t e;
      bit           pop_m;
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         mpc     = RESET_PC;
         mmis    = 1'b0;
         started = 1'b1;
      end else begin
         pop_m = (mq.size() != 0) && out_ready;
         if (pop_m) void'(mq.pop_front());
         if (redirect_valid) begin
            mq.delete();
            exp_q.delete();
            mpc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
         end else if (mq.size() < DEPTH) begin
            e.pc    = mpc;
            e.instr = mem[mpc[11:2]];
            mq.push_back(e);
            exp_q.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
   end

   // Monitor: sample on the falling edge, compare against the scoreboard.
   always @(negedge clk) begin
      if (started) begin
         check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("imem_pc", imem_pc, mpc);
         check("misalign_err", 32'(misalign_err), 32'(mmis));
         if (!out_valid) begin
            check("idle_instr", out_instr, NOP_INSTR);
            check("idle_pc", out_pc, 32'd0);
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head: valid with no expected entry, got pc %h at %0t", out_pc, $time);
         end else begin
            check("head_pc", out_pc, exp_q[0].pc);
            check("head_instr", out_instr, exp_q[0].instr);
            if (out_ready) begin
               void'(exp_q.pop_front());
               delivered++;
            end
         end
      end
   end

   initial begin
      logic        r;
      logic        rv;
      logic        rdy;
      logic [31:0] rp;

      for (int i = 0; i < 1024; i++)
         mem[i] = ($urandom & 32'hFFFF_FC00) | 32'(i);

      // Reset, then streaming with decode always ready.
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Decode stalled after reset: buffer fills and fetch stalls.
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Full buffer with simultaneous push and pop.
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Redirect with two entries buffered.
      repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 32'h40, 1'b1);
      repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Misaligned redirect, sticky flag, then aligned redirect.
      cyc(1'b1, 1'b1, 32'h42, 1'b0);
      repeat (10) cyc(1'b1, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
      cyc(1'b1, 1'b1, 32'h100, 1'b1);
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Back-to-back redirects, then PC wrap at the top of the address space.
      cyc(1'b1, 1'b1, 32'h200, 1'b1);
      cyc(1'b1, 1'b1, 32'h300, 1'b1);
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);
      cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Reset wins over a concurrent redirect with the buffer full.
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 32'h80, 1'b1);
      repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      // Random mix of stalls, redirects (any alignment) and rare resets.
      repeat (600) begin
         r   = 1'($urandom_range(0, 63) != 0);
         rv  = 1'($urandom_range(0, 7) == 0);
         rp  = $urandom;
         rdy = 1'($urandom_range(0, 3) != 0);
         cyc(r, rv, rp, rdy);
      end
      repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1);

      checks++;
      if (delivered < 200) begin
         errors++;
         $display("FAIL delivered: got %0d handshakes required at least 200", delivered);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the RISC-V core: owns the fetch PC and drives it to the combinational instruction memory.
- Captures the returned instruction word, paired with its PC, into a small in-order buffer.
- Presents buffered instructions to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump) from execute, which flushes the buffer and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_pc  out  32  address to instruction memory; equals fetch_pc combinationally.
- imem_instr  in  32  instruction word for imem_pc, valid in the same cycle (zero-latency memory).
- redirect_valid  in  1  execute requests a fetch restart.
- redirect_pc  in  32  restart target.
- out_valid  out  1  buffer head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0.
- out_pc  out  32  PC of head instruction; 0 when out_valid=0.
- misalign_err  out  1  sticky flag: a misaligned redirect target was received.

Behaviour:
- Reset (rst_n=0 at a clk edge): fetch_pc<=RESET_PC, buffer count/rd_ptr/wr_ptr<=0, misalign_err<=0.
  - Outputs after reset: out_valid=0, out_instr=NOP, out_pc=0, imem_pc=RESET_PC.
  - Reset takes priority over every other event, including a mid-operation redirect or a full buffer.
- Buffer: circular FIFO of {pc, instr}, with count in 0..BUF_DEPTH.
  - out_valid = (count != 0).
  - out_instr and out_pc are driven combinationally from the entry at rd_ptr.
- pop = out_valid & out_ready; rd_ptr advances, wrapping modulo BUF_DEPTH.
- push = !redirect_valid & (count < BUF_DEPTH | pop).
  - On push: the entry {fetch_pc, imem_instr} is written at wr_ptr, wr_ptr advances, and fetch_pc <= fetch_pc + 4 (modulo 2^32, wraps 0xFFFF_FFFC -> 0).
  - Full and pop in the same cycle: push is allowed, count stays BUF_DEPTH, order is preserved.
  - Full with no pop: no push, and fetch_pc holds (stall).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: the first instruction is visible (out_valid=1) one cycle after the reset release edge. Steady-state throughput is 1 instruction/cycle when out_ready=1.
- Redirect (redirect_valid=1, no reset):
  - count, rd_ptr, wr_ptr <= 0 (flush).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - If pop occurs in the same cycle, the handshake still counts as complete toward decode (decode discards it via its own flush); the buffer is flushed regardless.
  - Result: out_valid=0 in the cycle after the redirect; the target instruction is at the head two cycles after the redirect.
- misalign_err: set when redirect_valid=1 and redirect_pc[1:0] != 0. It stays set until reset and does not stall fetch.
- Back-to-back redirects: each one is honoured; the last one wins.
- out_ready asserted while out_valid=0: no effect.

Decomposition:
- Shared package (core_pkg):
  - NOP_INSTR = 32'h0000_0013.
  - XLEN = 32.
  - Typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- One sub-module: fetch_buffer.
  - Parameterised FIFO of fetch_entry_t.
  - Ports: push/pop/flush, full/empty, head output.
  - fetch_unit keeps the PC register, the push/redirect logic and the output muxing.

Test Plan:
- Release reset with out_ready=1 held, memory preloaded with distinct words -> out_pc 0,4,8,12 on consecutive cycles starting one cycle after release; out_instr equals mem[out_pc>>2].
- out_ready=0 after reset for 4 cycles -> count saturates at 2, imem_pc holds 8, out_pc stays 0. Then out_ready=1 -> out_pc 0,4,8,12 with no gaps or duplicates.
- Buffer full with out_ready=1 (simultaneous push+pop) for 3 cycles -> count stays 2, out_pc advances by 4 each cycle, in order.
- redirect_valid=1, redirect_pc=0x40 with 2 entries buffered -> next cycle out_valid=0 and imem_pc=0x40; following cycle out_pc=0x40; no pre-redirect PC ever appears after the flush.
- Redirect to 0x42 -> imem_pc=0x40, misalign_err=1, still 1 after 10 further cycles and a second, aligned redirect; cleared only by rst_n=0.
- Assert rst_n=0 for one cycle mid-stream with buffer full and a concurrent redirect -> next cycle out_valid=0, out_instr=NOP, imem_pc=RESET_PC, misalign_err=0.
